// File: rtl/cpu_seq_pkg.sv
// Shared types and opcode constants for the cpu program sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    EXEC,
    DONE,
    ERROR
  } seq_state_t;

  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:13] == OPC_HALT;
  endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// Program RAM for the sequencer: one write port and a registered read port.
module seq_prog_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  // Storage itself is never reset so a program survives a reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_program_sequencer.sv
// Feeds a stored program to the cpu one instruction at a time over the in/load/s -> w handshake.
// Define PROG_HALT_EN to make a fetched 3'b111 opcode end the run without being issued.
module cpu_program_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter int  TIMEOUT = 64,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_wdata,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              cpu_w,
  input  logic [15:0]       cpu_out,
  input  logic [2:0]        cpu_nvz,
  output logic [15:0]       cpu_in,
  output logic              cpu_load,
  output logic              cpu_s,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   issued,
  output logic [15:0]       last_out,
  output logic [2:0]        last_nvz
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

  seq_state_t state_q, state_d;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_clamped;
  logic [TW-1:0]   timer_q;
  logic [15:0]     instr;
  logic            idle_like;
  logic            halt_word;
  logic            last_instr;
  logic            timed_out;

  assign idle_like   = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);
  assign busy        = !idle_like;
  assign done        = (state_q == DONE);
  assign err         = (state_q == ERROR);
  assign cpu_in      = instr;
  assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign last_instr  = (issued + (ADDR_W + 1)'(1)) == len_q;
  assign timed_out   = timer_q == TW'(TIMEOUT - 1);

`ifdef PROG_HALT_EN
  assign halt_word = is_halt(instr);
`else
  assign halt_word = 1'b0;
`endif

  // Host writes are only accepted while no run is using the RAM.
  seq_prog_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (prog_we && idle_like),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .re    (state_q == FETCH),
    .raddr (pc),
    .rdata (instr)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cpu_load = 1'b0;
    cpu_s    = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) state_d = (prog_len == '0) ? DONE : FETCH;
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        if (halt_word) begin
          state_d = DONE;
        end else if (cpu_w) begin
          cpu_load = 1'b1;
          cpu_s    = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cpu_w)          state_d = last_instr ? DONE : FETCH;
        else if (timed_out) state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run bookkeeping: counters, captured results and the EXEC watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      issued   <= '0;
      len_q    <= '0;
      timer_q  <= '0;
      last_out <= '0;
      last_nvz <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            pc     <= '0;
            issued <= '0;
            len_q  <= len_clamped;
          end
        end
        ISSUE: timer_q <= '0;
        EXEC: begin
          if (cpu_w) begin
            last_out <= cpu_out;
            last_nvz <= cpu_nvz;
            issued   <= issued + (ADDR_W + 1)'(1);
            if (!last_instr) pc <= pc + ADDR_W'(1);
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
